io_cell_cfg_sequencer: RTL



---
 rtl/io_cell_cfg_sequencer.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/io_cell_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// io_cell_cfg_sequencer
//
// Register-programmable configuration store for the IO cell ring. Software
// writes per-cell shadow configs over a simple request/ready register bus and
// then commits them. A sequencer walks the cells in index order. It copies
// each differing shadow entry into the active config, one cell at a time, and
// inserts a settle gap after every applied change. This limits how many pads
// switch at once.
//
// Ports:
//   clk, reset      - single clock, synchronous active-high reset
//   reg_req/reg_we  - register request (held until reg_ready) and write flag
//   reg_addr        - word index (see address map below)
//   reg_wdata       - write data
//   reg_rdata       - read data, valid with reg_ready
//   reg_ready       - one-cycle completion pulse, one cycle after acceptance
//   reg_err         - error flag, valid with reg_ready
//   cell_cfg        - flat active config, cell i at [(i+1)*W-1 : i*W]
//   busy            - sequencer is walking cells
//   commit_done     - one-cycle pulse when a commit finishes
//
// Address map (N = IOCELL_COUNT):
//   0..N-1 SHADOW[i]   R/W (bits [W-1:0])
//   N      CTRL        W: bit0 starts a commit, bit1 sets LOCK (if built); reads 0
//   N+1    STATUS      RO: bit0 busy, bit1 lock, bits[15:8] current cell index
//   N+2    ACTIVE_SEL  R/W cell index
//   N+3    ACTIVE      RO: ACTIVE[ACTIVE_SEL], error if ACTIVE_SEL >= N
//   other  error, write ignored, read 0
//
// Optional feature macro: IOCELL_CFG_LOCK_EN
//   When defined, CTRL bit1 is a sticky write-1 lock, cleared only by reset.
//   The lock blocks writes to SHADOW, commit starts and ACTIVE_SEL writes.
//   When undefined, no lock logic is built and STATUS bit1 reads 0.
// -----------------------------------------------------------------------------
module io_cell_cfg_sequencer #(
  parameter int IOCELL_COUNT  = 28,
  parameter int IOCELL_CFG_W  = 5,
  parameter int SETTLE_CYCLES = 4,
  parameter logic [IOCELL_COUNT*IOCELL_CFG_W-1:0] RESET_CFG = '0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 reg_req,
  input  logic                                 reg_we,
  input  logic [7:0]                           reg_addr,
  input  logic [31:0]                          reg_wdata,
  output logic [31:0]                          reg_rdata,
  output logic                                 reg_ready,
  output logic                                 reg_err,
  output logic [IOCELL_COUNT*IOCELL_CFG_W-1:0] cell_cfg,
  output logic                                 busy,
  output logic                                 commit_done
);

  localparam int N     = IOCELL_COUNT;
  localparam int W     = IOCELL_CFG_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  // Register addresses are compared at 9 bits because N+3 can exceed 255.
  localparam logic [8:0]       ADDR_CTRL   = 9'(N);
  localparam logic [8:0]       ADDR_STATUS = 9'(N + 1);
  localparam logic [8:0]       ADDR_SEL    = 9'(N + 2);
  localparam logic [8:0]       ADDR_ACTIVE = 9'(N + 3);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SETTLE
  } state_t;

  // Config storage. It is kept in flops because every active entry drives
  // the frame in parallel and the whole store must reset in one cycle.
  logic [W-1:0]     shadow_reg [N];
  logic [W-1:0]     active_reg [N];
  logic [W-1:0]     reset_cell [N];
  logic [7:0]       active_sel_reg;

  state_t           state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [7:0]       settle_cnt_reg;
  logic             busy_reg;
  logic             commit_done_reg;

  logic             reg_ready_reg;
  logic             reg_err_reg;
  logic [31:0]      reg_rdata_reg;

  logic [8:0]       addr_ext;
  logic [IDX_W-1:0] addr_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_in_range;
  logic             accept;
  logic             locked;
  logic             cell_differs;
  logic             last_cell;

  logic             acc_err;
  logic [31:0]      acc_rdata;
  logic             shadow_we;
  logic             sel_we;
  logic             start_commit;

  // Only a few wdata bits are architecturally meaningful.
  logic             unused_wdata;
  assign unused_wdata = ^reg_wdata;

  for (genvar gi = 0; gi < N; gi++) begin : g_cell
    assign reset_cell[gi]        = RESET_CFG[gi*W +: W];
    assign cell_cfg[gi*W +: W]   = active_reg[gi];
  end

  assign addr_ext     = {1'b0, reg_addr};
  assign addr_idx     = reg_addr[IDX_W-1:0];
  assign sel_idx      = active_sel_reg[IDX_W-1:0];
  assign sel_in_range = ({1'b0, active_sel_reg} < ADDR_CTRL);

  // A request still high during its own ready cycle is the tail of the
  // previous access, not a new one.
  assign accept       = reg_req & ~reg_ready_reg;

  assign cell_differs = (shadow_reg[idx_reg] != active_reg[idx_reg]);
  assign last_cell    = (idx_reg == LAST_IDX);

`ifdef IOCELL_CFG_LOCK_EN
  logic lock_reg;
  logic lock_set;

  // CTRL writes are refused while busy, and so is the lock request.
  assign lock_set = accept & reg_we & (addr_ext == ADDR_CTRL) & ~busy_reg & reg_wdata[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_reg <= 1'b0;
    end else if (lock_set) begin
      lock_reg <= 1'b1;
    end
  end

  assign locked = lock_reg;
`else
  assign locked = 1'b0;
`endif

  // Register access decode: error/read data plus the side-effect strobes.
  always_comb begin
    acc_err      = 1'b0;
    acc_rdata    = '0;
    shadow_we    = 1'b0;
    sel_we       = 1'b0;
    start_commit = 1'b0;
    if (addr_ext < ADDR_CTRL) begin
      if (reg_we) begin
        if (busy_reg || locked) acc_err = 1'b1;
        else                    shadow_we = 1'b1;
      end else begin
        acc_rdata = 32'(shadow_reg[addr_idx]);
      end
    end else if (addr_ext == ADDR_CTRL) begin
      if (reg_we) begin
        if (busy_reg) begin
          acc_err = 1'b1;
        end else if (reg_wdata[0]) begin
          if (locked) acc_err = 1'b1;
          else        start_commit = 1'b1;
        end
      end
    end else if (addr_ext == ADDR_STATUS) begin
      if (!reg_we) begin
        acc_rdata = {16'd0, 8'(idx_reg), 6'd0, locked, busy_reg};
      end
    end else if (addr_ext == ADDR_SEL) begin
      if (reg_we) begin
        if (locked) acc_err = 1'b1;
        else        sel_we = 1'b1;
      end else begin
        acc_rdata = 32'(active_sel_reg);
      end
    end else if (addr_ext == ADDR_ACTIVE) begin
      if (!reg_we) begin
        if (sel_in_range) acc_rdata = 32'(active_reg[sel_idx]);
        else              acc_err = 1'b1;
      end
    end else begin
      acc_err = 1'b1;
    end
    if (!accept) begin
      shadow_we    = 1'b0;
      sel_we       = 1'b0;
      start_commit = 1'b0;
    end
  end

  // Bus response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_ready_reg <= 1'b0;
      reg_err_reg   <= 1'b0;
      reg_rdata_reg <= '0;
    end else begin
      reg_ready_reg <= accept;
      reg_err_reg   <= accept & acc_err;
      reg_rdata_reg <= accept ? acc_rdata : '0;
    end
  end

  // Shadow store and active selector.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) shadow_reg[i] <= reset_cell[i];
      active_sel_reg <= '0;
    end else begin
      if (shadow_we) shadow_reg[addr_idx] <= reg_wdata[W-1:0];
      if (sel_we)    active_sel_reg <= reg_wdata[7:0];
    end
  end

  // Commit sequencer. Active entries change only from SCAN, one per step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      settle_cnt_reg  <= '0;
      busy_reg        <= 1'b0;
      commit_done_reg <= 1'b0;
      for (int i = 0; i < N; i++) active_reg[i] <= reset_cell[i];
    end else begin
      commit_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_commit) begin
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= SCAN;
          end
        end
        SCAN: begin
          if (cell_differs) active_reg[idx_reg] <= shadow_reg[idx_reg];
          // With no settle gap a changed cell advances like an unchanged one.
          if (cell_differs && (SETTLE_CYCLES != 0)) begin
            settle_cnt_reg <= 8'(SETTLE_CYCLES);
            state_reg      <= SETTLE;
          end else if (last_cell) begin
            state_reg       <= IDLE;
            busy_reg        <= 1'b0;
            commit_done_reg <= 1'b1;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        SETTLE: begin
          // Counter is loaded with SETTLE_CYCLES, so the gap spans exactly
          // that many cycles.
          if (settle_cnt_reg == 8'd1) begin
            if (last_cell) begin
              state_reg       <= IDLE;
              busy_reg        <= 1'b0;
              commit_done_reg <= 1'b1;
            end else begin
              idx_reg   <= idx_reg + 1'b1;
              state_reg <= SCAN;
            end
          end else begin
            settle_cnt_reg <= settle_cnt_reg - 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign reg_ready   = reg_ready_reg;
  assign reg_err     = reg_err_reg;
  assign reg_rdata   = reg_rdata_reg;
  assign busy        = busy_reg;
  assign commit_done = commit_done_reg;

endmodule
